// File: rtl/kypd_pkg.sv
// rtl/kypd_pkg.sv - shared types, column drive constants and key map for the keypad scanner
package kypd_pkg;

    typedef enum logic [1:0] {
        RES_NONE   = 2'd0,
        RES_SINGLE = 2'd1,
        RES_MULTI  = 2'd2
    } res_kind_t;

    // code is forced to 0 for NONE/MULTI so whole-struct equality is meaningful
    typedef struct packed {
        res_kind_t  kind;
        logic [3:0] code;
    } frame_res_t;

    typedef enum logic [1:0] {
        ST_RELEASED = 2'd0,
        ST_PRESSED  = 2'd1,
        ST_ROLL     = 2'd2
    } key_state_t;

    localparam logic [3:0] COL_IDLE = 4'b1111;
    localparam logic [3:0] COL_0    = 4'b1110;
    localparam logic [3:0] COL_1    = 4'b1101;
    localparam logic [3:0] COL_2    = 4'b1011;
    localparam logic [3:0] COL_3    = 4'b0111;

    // nibble index is {row, col}
    localparam logic [63:0] KEY_MAP = 64'hDEF0_C987_B654_A321;

    function automatic logic [3:0] key_hex(input logic [1:0] row, input logic [1:0] col);
        return KEY_MAP[{row, col, 2'b00} +: 4];
    endfunction

    function automatic logic [3:0] col_drive(input logic [1:0] idx);
        case (idx)
            2'd0:    return COL_0;
            2'd1:    return COL_1;
            2'd2:    return COL_2;
            default: return COL_3;
        endcase
    endfunction

endpackage

// File: rtl/kypd_frame_debounce.sv
// rtl/kypd_frame_debounce.sv - requires N identical frame results before reporting them
module kypd_frame_debounce
    import kypd_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  frame_res_t frame_res,
    input  logic       frame_end,
    output frame_res_t deb_res,
    output logic       deb_strobe
);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_SCANS);

    frame_res_t    prev;
    logic [CW-1:0] count;
    logic [CW-1:0] next_count;

    always_comb begin
        next_count = CW'(1);
        if (frame_res == prev) begin
            next_count = (count == CNT_MAX) ? CNT_MAX : count + CW'(1);
        end
    end

    assign deb_strobe = frame_end && (next_count == CNT_MAX);
    assign deb_res    = frame_res;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            prev  <= '{kind: RES_NONE, code: 4'h0};
            count <= '0;
        end else if (frame_end) begin
            prev  <= frame_res;
            count <= next_count;
        end
    end

endmodule

// File: rtl/kypd_scan_core.sv
// rtl/kypd_scan_core.sv - 4x4 keypad column scanner with frame debounce and press/release pulses
module kypd_scan_core
    import kypd_pkg::*;
#(
    parameter int CLK_FREQUENCY_HZ   = 50000000,
    parameter int SCAN_PERIOD_CYCLES = CLK_FREQUENCY_HZ / 1000,
    parameter int DEBOUNCE_SCANS     = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] ROW,
    output logic [3:0] COL,
    output logic [3:0] KEY_CODE,
    output logic       KEY_VALID,
    output logic       KEY_PRESS,
    output logic       KEY_RELEASE,
    output logic       MULTI_KEY
);
    localparam int TW = $clog2(SCAN_PERIOD_CYCLES);
    localparam logic [TW-1:0] TMAX = TW'(SCAN_PERIOD_CYCLES - 1);

    logic [3:0]    row_meta, row_sync;
    logic          running;
    logic [TW-1:0] timer;
    logic [1:0]    col_idx;
    logic [1:0]    acc_hits;
    logic [3:0]    acc_code;
    logic          sample, frame_end;
    logic [3:0]    row_low;
    logic [2:0]    col_cnt, sum;
    logic [1:0]    row_sel, hits_next;
    logic [3:0]    code_next;
    frame_res_t    frame_res, deb_res;
    logic          deb_strobe;
    key_state_t    state;
    logic [3:0]    pend_code;

    assign sample    = running && (timer == TMAX);
    assign frame_end = sample && (col_idx == 2'd3);
    assign row_low   = ~row_sync;

    always_comb begin
        col_cnt = 3'(row_low[0]) + 3'(row_low[1]) + 3'(row_low[2]) + 3'(row_low[3]);
        row_sel = 2'd0;
        if      (row_low[0]) row_sel = 2'd0;
        else if (row_low[1]) row_sel = 2'd1;
        else if (row_low[2]) row_sel = 2'd2;
        else if (row_low[3]) row_sel = 2'd3;
        sum       = {1'b0, acc_hits} + col_cnt;
        hits_next = (sum >= 3'd2) ? 2'd2 : sum[1:0];
        code_next = (col_cnt == 3'd1) ? key_hex(row_sel, col_idx) : acc_code;
        frame_res = '{kind: RES_NONE, code: 4'h0};
        if (hits_next == 2'd1) frame_res = '{kind: RES_SINGLE, code: code_next};
        else if (hits_next == 2'd2) frame_res = '{kind: RES_MULTI, code: 4'h0};
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
            running  <= 1'b0;
            timer    <= '0;
            col_idx  <= 2'd0;
            COL      <= COL_IDLE;
            acc_hits <= 2'd0;
            acc_code <= 4'h0;
        end else begin
            row_meta <= ROW;
            row_sync <= row_meta;
            // first cycle out of reset only starts the walk so column 0 gets a full period
            if (!running) begin
                running <= 1'b1;
                COL     <= COL_0;
            end else if (timer == TMAX) begin
                timer   <= '0;
                col_idx <= col_idx + 2'd1;
                COL     <= col_drive(col_idx + 2'd1);
            end else begin
                timer <= timer + TW'(1);
            end
            if (sample) begin
                if (col_idx == 2'd3) begin
                    acc_hits <= 2'd0;
                    acc_code <= 4'h0;
                end else begin
                    acc_hits <= hits_next;
                    acc_code <= code_next;
                end
            end
        end
    end

    kypd_frame_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
        .CLK       (CLK),
        .RESET     (RESET),
        .frame_res (frame_res),
        .frame_end (frame_end),
        .deb_res   (deb_res),
        .deb_strobe(deb_strobe)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= ST_RELEASED;
            pend_code   <= 4'h0;
            KEY_CODE    <= 4'h0;
            KEY_VALID   <= 1'b0;
            KEY_PRESS   <= 1'b0;
            KEY_RELEASE <= 1'b0;
            MULTI_KEY   <= 1'b0;
        end else begin
            KEY_PRESS   <= 1'b0;
            KEY_RELEASE <= 1'b0;
            if (deb_strobe) MULTI_KEY <= (deb_res.kind == RES_MULTI);
            case (state)
                ST_RELEASED: begin
                    if (deb_strobe && deb_res.kind == RES_SINGLE) begin
                        state     <= ST_PRESSED;
                        KEY_CODE  <= deb_res.code;
                        KEY_VALID <= 1'b1;
                        KEY_PRESS <= 1'b1;
                    end
                end
                ST_PRESSED: begin
                    if (deb_strobe && deb_res.kind != RES_SINGLE) begin
                        state       <= ST_RELEASED;
                        KEY_VALID   <= 1'b0;
                        KEY_RELEASE <= 1'b1;
                    end else if (deb_strobe && deb_res.code != KEY_CODE) begin
                        state       <= ST_ROLL;
                        pend_code   <= deb_res.code;
                        KEY_VALID   <= 1'b0;
                        KEY_RELEASE <= 1'b1;
                    end
                end
                default: begin
                    // roll-over: release of the old key was shown last cycle
                    state     <= ST_PRESSED;
                    KEY_CODE  <= pend_code;
                    KEY_VALID <= 1'b1;
                    KEY_PRESS <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kypd_scan_core.sv
// tb/tb_kypd_scan_core.sv - directed self-checking bench for kypd_scan_core
module tb_kypd_scan_core;
    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [3:0]  ROW;
    logic [3:0]  COL;
    logic [3:0]  KEY_CODE;
    logic        KEY_VALID, KEY_PRESS, KEY_RELEASE, MULTI_KEY;
    logic [15:0] keys = 16'h0000;
    logic [3:0]  walk_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    int checks = 0;
    int failures = 0;
    int t = 0;
    int press_cnt = 0, release_cnt = 0, press_t = -1, release_t = -1;

    localparam logic [15:0] K_1 = 16'h0001;
    localparam logic [15:0] K_5 = 16'h0020;
    localparam logic [15:0] K_C = 16'h0800;
    localparam logic [15:0] K_D = 16'h8000;

    always #5 CLK = ~CLK;

    // keypad model: key (r,c) pulls row r low while column c is driven low
    always_comb begin
        ROW = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !COL[c]) ROW[r] = 1'b0;
    end

    kypd_scan_core #(
        .CLK_FREQUENCY_HZ  (50000000),
        .SCAN_PERIOD_CYCLES(8),
        .DEBOUNCE_SCANS    (3)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .ROW        (ROW),
        .COL        (COL),
        .KEY_CODE   (KEY_CODE),
        .KEY_VALID  (KEY_VALID),
        .KEY_PRESS  (KEY_PRESS),
        .KEY_RELEASE(KEY_RELEASE),
        .MULTI_KEY  (MULTI_KEY)
    );

    task automatic step();
        @(posedge CLK);
        #1;
        t++;
        if (KEY_PRESS)   begin press_cnt++;   press_t = t;   end
        if (KEY_RELEASE) begin release_cnt++; release_t = t; end
    endtask

    task automatic run_to(input int target);
        while (t < target) step();
    endtask

    task automatic hold_reset();
        RESET = 1'b1;
        repeat (5) step();
    endtask

    task automatic release_reset();
        RESET = 1'b0;
        t = -1;
        press_cnt = 0; release_cnt = 0; press_t = -1; release_t = -1;
        step();
    endtask

    task automatic test_reset();
        hold_reset();
        checks++;
        if (COL !== 4'b1111) begin failures++; $display("FAIL reset_col: got %b expected 1111", COL); end
        checks++;
        if ({KEY_CODE, KEY_VALID, KEY_PRESS, KEY_RELEASE, MULTI_KEY} !== 8'h00) begin
            failures++;
            $display("FAIL reset_outputs: got %h expected 00", {KEY_CODE, KEY_VALID, KEY_PRESS, KEY_RELEASE, MULTI_KEY});
        end
    endtask

    task automatic test_walk();
        logic [3:0] exp_col;
        release_reset();
        while (t <= 70) begin
            exp_col = walk_tab[(t / 8) % 4];
            checks++;
            if (COL !== exp_col) begin failures++; $display("FAIL walk_col t=%0d: got %b expected %b", t, COL, exp_col); end
            step();
        end
    endtask

    task automatic test_clean_press();
        hold_reset();
        keys = K_5;
        release_reset();
        run_to(127);
        checks++;
        if (press_cnt !== 1) begin failures++; $display("FAIL press_count: got %0d expected 1", press_cnt); end
        checks++;
        if (press_t !== 96) begin failures++; $display("FAIL press_time: got %0d expected 96", press_t); end
        checks++;
        if (KEY_CODE !== 4'h5) begin failures++; $display("FAIL press_code: got %h expected 5", KEY_CODE); end
        checks++;
        if (KEY_VALID !== 1'b1) begin failures++; $display("FAIL press_valid: got %b expected 1", KEY_VALID); end
    endtask

    task automatic test_release();
        run_to(128);
        keys = 16'h0000;
        run_to(260);
        checks++;
        if (release_cnt !== 1) begin failures++; $display("FAIL release_count: got %0d expected 1", release_cnt); end
        checks++;
        if (release_t !== 224) begin failures++; $display("FAIL release_time: got %0d expected 224", release_t); end
        checks++;
        if (KEY_VALID !== 1'b0) begin failures++; $display("FAIL release_valid: got %b expected 0", KEY_VALID); end
        checks++;
        if (KEY_CODE !== 4'h5) begin failures++; $display("FAIL release_code_hold: got %h expected 5", KEY_CODE); end
        checks++;
        if (press_cnt !== 1) begin failures++; $display("FAIL release_no_repress: got %0d expected 1", press_cnt); end
    endtask

    task automatic test_bounce();
        hold_reset();
        keys = 16'h0000;
        release_reset();
        while (t < 300) begin
            if (t < 150) keys = ((t / 20) % 2 == 0) ? K_5 : 16'h0000;
            else keys = K_5;
            step();
        end
        checks++;
        if (press_cnt !== 1) begin failures++; $display("FAIL bounce_press_count: got %0d expected 1", press_cnt); end
        checks++;
        if (press_t !== 256) begin failures++; $display("FAIL bounce_press_time: got %0d expected 256", press_t); end
        checks++;
        if (release_cnt !== 0) begin failures++; $display("FAIL bounce_release_count: got %0d expected 0", release_cnt); end
    endtask

    task automatic test_multi();
        hold_reset();
        keys = K_1 | K_D;
        release_reset();
        run_to(95);
        checks++;
        if (MULTI_KEY !== 1'b0) begin failures++; $display("FAIL multi_early: got %b expected 0", MULTI_KEY); end
        step();
        checks++;
        if (MULTI_KEY !== 1'b1) begin failures++; $display("FAIL multi_set: got %b expected 1", MULTI_KEY); end
        run_to(130);
        checks++;
        if (MULTI_KEY !== 1'b1) begin failures++; $display("FAIL multi_hold: got %b expected 1", MULTI_KEY); end
        checks++;
        if (press_cnt + release_cnt !== 0) begin
            failures++;
            $display("FAIL multi_pulses: got %0d expected 0", press_cnt + release_cnt);
        end
        checks++;
        if (KEY_VALID !== 1'b0) begin failures++; $display("FAIL multi_valid: got %b expected 0", KEY_VALID); end
    endtask

    task automatic test_roll();
        hold_reset();
        keys = K_5;
        release_reset();
        run_to(128);
        keys = K_5 | K_C;
        run_to(160);
        keys = K_C;
        run_to(255);
        checks++;
        if (release_cnt !== 0) begin failures++; $display("FAIL roll_early_release: got %0d expected 0", release_cnt); end
        step();
        checks++;
        if ({KEY_RELEASE, KEY_VALID, KEY_PRESS} !== 3'b100) begin
            failures++;
            $display("FAIL roll_cycle_n: got %b expected 100", {KEY_RELEASE, KEY_VALID, KEY_PRESS});
        end
        checks++;
        if (KEY_CODE !== 4'h5) begin failures++; $display("FAIL roll_code_n: got %h expected 5", KEY_CODE); end
        step();
        checks++;
        if ({KEY_RELEASE, KEY_VALID, KEY_PRESS} !== 3'b011) begin
            failures++;
            $display("FAIL roll_cycle_n1: got %b expected 011", {KEY_RELEASE, KEY_VALID, KEY_PRESS});
        end
        checks++;
        if (KEY_CODE !== 4'hC) begin failures++; $display("FAIL roll_code_n1: got %h expected c", KEY_CODE); end
        run_to(300);
        checks++;
        if (press_cnt !== 2) begin failures++; $display("FAIL roll_press_count: got %0d expected 2", press_cnt); end
        checks++;
        if (release_cnt !== 1) begin failures++; $display("FAIL roll_release_count: got %0d expected 1", release_cnt); end
        checks++;
        if (MULTI_KEY !== 1'b0) begin failures++; $display("FAIL roll_multi: got %b expected 0", MULTI_KEY); end
    endtask

    task automatic test_reset_mid_press();
        hold_reset();
        keys = K_5;
        release_reset();
        run_to(100);
        checks++;
        if (KEY_VALID !== 1'b1) begin failures++; $display("FAIL mid_pre_valid: got %b expected 1", KEY_VALID); end
        RESET = 1'b1;
        step();
        checks++;
        if (COL !== 4'b1111) begin failures++; $display("FAIL mid_col: got %b expected 1111", COL); end
        checks++;
        if ({KEY_CODE, KEY_VALID, KEY_PRESS, KEY_RELEASE, MULTI_KEY} !== 8'h00) begin
            failures++;
            $display("FAIL mid_outputs: got %h expected 00", {KEY_CODE, KEY_VALID, KEY_PRESS, KEY_RELEASE, MULTI_KEY});
        end
        repeat (3) step();
        release_reset();
        checks++;
        if ({KEY_PRESS, KEY_RELEASE} !== 2'b00) begin
            failures++;
            $display("FAIL mid_deassert_pulse: got %b expected 00", {KEY_PRESS, KEY_RELEASE});
        end
        run_to(130);
        checks++;
        if (press_cnt !== 1) begin failures++; $display("FAIL mid_press_count: got %0d expected 1", press_cnt); end
        checks++;
        if (press_t !== 96) begin failures++; $display("FAIL mid_press_time: got %0d expected 96", press_t); end
    endtask

    initial begin
        test_reset();
        test_walk();
        test_clean_press();
        test_release();
        test_bounce();
        test_multi();
        test_roll();
        test_reset_mid_press();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
